// File: rtl/asap1_pkg.sv
// Shared definitions for the ASAP-1 datapath: opcodes, T-state numbers and
// the control word that the sequencer drives onto the datapath.
package asap1_pkg;

    localparam int OPCODE_BITS = 4;
    localparam int STEP_BITS   = 3;

    localparam logic [OPCODE_BITS-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_BITS-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_BITS-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_BITS-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_BITS-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_BITS-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_BITS-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_BITS-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_BITS-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_BITS-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_BITS-1:0] OP_HLT = 4'hF;

    localparam logic [STEP_BITS-1:0] T0 = 3'd0;
    localparam logic [STEP_BITS-1:0] T1 = 3'd1;
    localparam logic [STEP_BITS-1:0] T2 = 3'd2;
    localparam logic [STEP_BITS-1:0] T3 = 3'd3;
    localparam logic [STEP_BITS-1:0] T4 = 3'd4;

    // Field order is the bit order of the packed word, MSB first.
    typedef struct packed {
        logic co;
        logic ce;
        logic j;
        logic mi;
        logic ri;
        logic ro;
        logic ii;
        logic io;
        logic ai;
        logic ao;
        logic bi;
        logic eo;
        logic su;
        logic fi;
        logic oi;
        logic hlt;
    } ctrl_t;

endpackage

// File: rtl/control_rom.sv
// Combinational microcode: maps (opcode, T-state, latched flags) to the
// control word and flags the final step of the current instruction.
module control_rom
    import asap1_pkg::*;
(
    input  logic [OPCODE_BITS-1:0] opcode_i,
    input  logic [STEP_BITS-1:0]   step_i,
    input  logic                   zf_i,
    input  logic                   cf_i,
    output ctrl_t                  ctrl_o,
    output logic                   last_step_o
);

    always_comb begin
        ctrl_o      = '0;
        last_step_o = 1'b0;
        case (step_i)
            T0: begin
                ctrl_o.co = 1'b1;
                ctrl_o.mi = 1'b1;
            end
            T1: begin
                ctrl_o.ro = 1'b1;
                ctrl_o.ii = 1'b1;
                ctrl_o.ce = 1'b1;
            end
            T2: begin
                last_step_o = 1'b1;
                case (opcode_i)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                        ctrl_o.io   = 1'b1;
                        ctrl_o.mi   = 1'b1;
                        last_step_o = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl_o.io = 1'b1;
                        ctrl_o.ai = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_o.io = 1'b1;
                        ctrl_o.j  = 1'b1;
                    end
                    // Untaken branches still spend T2 with nothing asserted.
                    OP_JC: begin
                        ctrl_o.io = cf_i;
                        ctrl_o.j  = cf_i;
                    end
                    OP_JZ: begin
                        ctrl_o.io = zf_i;
                        ctrl_o.j  = zf_i;
                    end
                    OP_OUT: begin
                        ctrl_o.ao = 1'b1;
                        ctrl_o.oi = 1'b1;
                    end
                    OP_HLT: ctrl_o.hlt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (opcode_i)
                    OP_LDA: begin
                        ctrl_o.ro   = 1'b1;
                        ctrl_o.ai   = 1'b1;
                        last_step_o = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_o.ao   = 1'b1;
                        ctrl_o.ri   = 1'b1;
                        last_step_o = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o.ro = 1'b1;
                        ctrl_o.bi = 1'b1;
                    end
                    default: last_step_o = 1'b1;
                endcase
            end
            T4: begin
                last_step_o = 1'b1;
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_o.eo = 1'b1;
                    ctrl_o.ai = 1'b1;
                    ctrl_o.fi = 1'b1;
                    ctrl_o.su = (opcode_i == OP_SUB);
                end
            end
            // Out-of-range steps fall back to fetch on the next edge.
            default: last_step_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ASAP-1 instruction sequencer: T-state counter, flags register and halt
// latch around the control ROM; outputs are a zero-latency decode.
module control_sequencer
    import asap1_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zf,
    input  logic                cf,
    output logic                co,
    output logic                ce,
    output logic                j,
    output logic                mi,
    output logic                ri,
    output logic                ro,
    output logic                ii,
    output logic                io,
    output logic                ai,
    output logic                ao,
    output logic                bi,
    output logic                eo,
    output logic                su,
    output logic                fi,
    output logic                oi,
    output logic                hlt,
    output logic [STEP_W-1:0]   step
);

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    ctrl_t             rom_ctrl, ctrl;
    logic              last_step;

    control_rom u_rom (
        .opcode_i    (opcode),
        .step_i      (step_q),
        .zf_i        (zf_q),
        .cf_i        (cf_q),
        .ctrl_o      (rom_ctrl),
        .last_step_o (last_step)
    );

    always_comb begin
        ctrl = rom_ctrl;
        if (rst) begin
            ctrl = '0;
        end else if (halted_q) begin
            ctrl     = '0;
            ctrl.hlt = 1'b1;
        end
    end

    // Step freezes at T2 both on the HLT edge and for as long as halted.
    always_comb begin
        step_d   = last_step ? '0 : step_q + STEP_W'(1);
        halted_d = halted_q | ctrl.hlt;
        zf_d     = zf_q;
        cf_d     = cf_q;
        if (halted_q || ctrl.hlt) begin
            step_d = step_q;
        end
        if (ctrl.fi) begin
            zf_d = zf;
            cf_d = cf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
        end
    end

    assign co   = ctrl.co;
    assign ce   = ctrl.ce;
    assign j    = ctrl.j;
    assign mi   = ctrl.mi;
    assign ri   = ctrl.ri;
    assign ro   = ctrl.ro;
    assign ii   = ctrl.ii;
    assign io   = ctrl.io;
    assign ai   = ctrl.ai;
    assign ao   = ctrl.ao;
    assign bi   = ctrl.bi;
    assign eo   = ctrl.eo;
    assign su   = ctrl.su;
    assign fi   = ctrl.fi;
    assign oi   = ctrl.oi;
    assign hlt  = ctrl.hlt;
    assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and swept checks of the ASAP-1 control sequencer using an
// expected-value queue of {step, control word} per clock.
module tb_control_sequencer;

    localparam int W = 19;

    localparam logic [15:0] CO  = 16'h8000;
    localparam logic [15:0] CE  = 16'h4000;
    localparam logic [15:0] J   = 16'h2000;
    localparam logic [15:0] MI  = 16'h1000;
    localparam logic [15:0] RI  = 16'h0800;
    localparam logic [15:0] RO  = 16'h0400;
    localparam logic [15:0] II  = 16'h0200;
    localparam logic [15:0] IO  = 16'h0100;
    localparam logic [15:0] AI  = 16'h0080;
    localparam logic [15:0] AO  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] EO  = 16'h0010;
    localparam logic [15:0] SU  = 16'h0008;
    localparam logic [15:0] FI  = 16'h0004;
    localparam logic [15:0] OI  = 16'h0002;
    localparam logic [15:0] HLT = 16'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zf, cf;
    logic       co, ce, j, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, hlt;
    logic [2:0] step;
    logic [15:0] ctl;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic mzf, mcf;

    always #5 clk = ~clk;

    assign ctl = {co, ce, j, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, hlt};

    control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .cf(cf),
        .co(co), .ce(ce), .j(j), .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io),
        .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .fi(fi), .oi(oi),
        .hlt(hlt), .step(step)
    );

    function automatic logic [15:0] model(input logic [3:0] op, input logic [2:0] st,
                                          input logic zq, input logic cq);
        case (st)
            3'd0: return CO | MI;
            3'd1: return RO | II | CE;
            3'd2: case (op)
                4'h1, 4'h2, 4'h3, 4'h4: return IO | MI;
                4'h5: return IO | AI;
                4'h6: return IO | J;
                4'h7: return cq ? (IO | J) : 16'h0;
                4'h8: return zq ? (IO | J) : 16'h0;
                4'hE: return AO | OI;
                4'hF: return HLT;
                default: return 16'h0;
            endcase
            3'd3: case (op)
                4'h1: return RO | AI;
                4'h2, 4'h3: return RO | BI;
                4'h4: return AO | RI;
                default: return 16'h0;
            endcase
            3'd4: case (op)
                4'h2: return EO | AI | FI;
                4'h3: return EO | AI | FI | SU;
                default: return 16'h0;
            endcase
            default: return 16'h0;
        endcase
    endfunction

    function automatic int last_of(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 3;
            4'h2, 4'h3: return 4;
            default:    return 2;
        endcase
    endfunction

    // Drive one cycle's inputs just after a rising edge, check on the falling edge.
    task automatic cycle(input string tag, input logic r, input logic [3:0] op,
                         input logic z, input logic c,
                         input logic [2:0] es, input logic [15:0] ec);
        logic [W-1:0] e, got;
        int drivers;
        rst = r; opcode = op; zf = z; cf = c;
        exp_q.push_back({es, ec});
        @(negedge clk);
        e   = exp_q.pop_front();
        got = {step, ctl};
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s: got step=%0d ctl=%h, want step=%0d ctl=%h",
                   tag, got[18:16], got[15:0], e[18:16], e[15:0]);
        end
        drivers = int'(co) + int'(ro) + int'(io) + int'(ao) + int'(eo);
        total++;
        assert ((drivers <= 1) && !(su && !eo)) else begin
            bad++;
            $error("FAIL %s_bus: got drivers=%0d su=%b eo=%b, want drivers<=1 and su only with eo",
                   tag, drivers, su, eo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [3:0] op, input logic z, input logic c);
        cycle(tag, 1'b0, op, z, c, 3'd0, CO | MI);
        cycle(tag, 1'b0, op, z, c, 3'd1, RO | II | CE);
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h0; zf = 1'b0; cf = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0);

        // NOP loop: period 3
        fetch("nop", 4'h0, 1'b0, 1'b0);
        cycle("nop_t2", 1'b0, 4'h0, 1'b0, 1'b0, 3'd2, 16'h0);
        cycle("nop_wrap", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, CO | MI);
        cycle("nop_t1b", 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, RO | II | CE);
        cycle("nop_t2b", 1'b0, 4'h0, 1'b0, 1'b0, 3'd2, 16'h0);

        // ADD with zf=0 cf=1 at T4
        fetch("add", 4'h2, 1'b0, 1'b1);
        cycle("add_t2", 1'b0, 4'h2, 1'b0, 1'b1, 3'd2, IO | MI);
        cycle("add_t3", 1'b0, 4'h2, 1'b0, 1'b1, 3'd3, RO | BI);
        cycle("add_t4", 1'b0, 4'h2, 1'b0, 1'b1, 3'd4, EO | AI | FI);
        // JC taken (cf_q=1), JZ not taken (zf_q=0); live zf/cf are ignored
        fetch("jc1", 4'h7, 1'b1, 1'b0);
        cycle("jc1_t2", 1'b0, 4'h7, 1'b1, 1'b0, 3'd2, IO | J);
        fetch("jz1", 4'h8, 1'b1, 1'b0);
        cycle("jz1_t2", 1'b0, 4'h8, 1'b1, 1'b0, 3'd2, 16'h0);

        // SUB with zf=1 cf=0, then JZ taken, JC not
        fetch("sub", 4'h3, 1'b1, 1'b0);
        cycle("sub_t2", 1'b0, 4'h3, 1'b1, 1'b0, 3'd2, IO | MI);
        cycle("sub_t3", 1'b0, 4'h3, 1'b1, 1'b0, 3'd3, RO | BI);
        cycle("sub_t4", 1'b0, 4'h3, 1'b1, 1'b0, 3'd4, EO | AI | FI | SU);
        fetch("jz2", 4'h8, 1'b0, 1'b1);
        cycle("jz2_t2", 1'b0, 4'h8, 1'b0, 1'b1, 3'd2, IO | J);
        fetch("jc2", 4'h7, 1'b0, 1'b1);
        cycle("jc2_t2", 1'b0, 4'h7, 1'b0, 1'b1, 3'd2, 16'h0);
        cycle("jc2_wrap", 1'b0, 4'h7, 1'b0, 1'b1, 3'd0, CO | MI);
        cycle("jc2_t1", 1'b0, 4'h7, 1'b0, 1'b1, 3'd1, RO | II | CE);
        cycle("jc2_t2b", 1'b0, 4'h7, 1'b0, 1'b1, 3'd2, 16'h0);

        // ADD setting both flags, then HLT
        fetch("add2", 4'h2, 1'b1, 1'b1);
        cycle("add2_t2", 1'b0, 4'h2, 1'b1, 1'b1, 3'd2, IO | MI);
        cycle("add2_t3", 1'b0, 4'h2, 1'b1, 1'b1, 3'd3, RO | BI);
        cycle("add2_t4", 1'b0, 4'h2, 1'b1, 1'b1, 3'd4, EO | AI | FI);
        fetch("hlt", 4'hF, 1'b0, 1'b0);
        cycle("hlt_t2", 1'b0, 4'hF, 1'b0, 1'b0, 3'd2, HLT);
        for (int k = 0; k < 10; k++) begin
            cycle("halted", 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'd2, HLT);
        end
        cycle("hlt_rst", 1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 16'h0);
        fetch("after_hlt_jz", 4'h8, 1'b0, 1'b0);
        cycle("after_hlt_jz_t2", 1'b0, 4'h8, 1'b0, 1'b0, 3'd2, 16'h0);
        fetch("after_hlt_jc", 4'h7, 1'b0, 1'b0);
        cycle("after_hlt_jc_t2", 1'b0, 4'h7, 1'b0, 1'b0, 3'd2, 16'h0);

        // Set flags, then reset during ADD T3
        fetch("add3", 4'h3, 1'b1, 1'b1);
        cycle("add3_t2", 1'b0, 4'h3, 1'b1, 1'b1, 3'd2, IO | MI);
        cycle("add3_t3", 1'b0, 4'h3, 1'b1, 1'b1, 3'd3, RO | BI);
        cycle("add3_t4", 1'b0, 4'h3, 1'b1, 1'b1, 3'd4, EO | AI | FI | SU);
        fetch("add4", 4'h2, 1'b1, 1'b1);
        cycle("add4_t2", 1'b0, 4'h2, 1'b1, 1'b1, 3'd2, IO | MI);
        cycle("add4_rst", 1'b1, 4'h2, 1'b1, 1'b1, 3'd3, 16'h0);
        cycle("add4_t0", 1'b0, 4'h2, 1'b1, 1'b1, 3'd0, CO | MI);
        cycle("add4_t1", 1'b0, 4'h2, 1'b1, 1'b1, 3'd1, RO | II | CE);
        cycle("add4_t2b", 1'b0, 4'h7, 1'b1, 1'b1, 3'd2, 16'h0);
        fetch("rst_jz", 4'h8, 1'b1, 1'b1);
        cycle("rst_jz_t2", 1'b0, 4'h8, 1'b1, 1'b1, 3'd2, 16'h0);

        // Sweep every non-halting opcode with random live flags
        mzf = 1'b0;
        mcf = 1'b0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int o = 0; o < 15; o++) begin
                for (int s = 0; s <= last_of(4'(o)); s++) begin
                    logic z, c;
                    logic [15:0] ec;
                    z  = 1'($urandom_range(0, 1));
                    c  = 1'($urandom_range(0, 1));
                    ec = model(4'(o), 3'(s), mzf, mcf);
                    cycle("sweep", 1'b0, 4'(o), z, c, 3'(s), ec);
                    if ((ec & FI) != 16'h0) begin
                        mzf = z;
                        mcf = c;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
